// File: rtl/ov5640_cfg_sequencer.sv
// OV5640 SCCB configuration sequencer: walks the register LUT and issues
// one I2C write per entry, with in-table delays, NACK retry and status.
module ov5640_cfg_sequencer #(
  parameter logic [7:0]  DEV_ADDR  = 8'h78,
  parameter int unsigned PWR_DLY   = 20'hFFFF0,
  parameter int unsigned GAP_CYC   = 16,
  parameter logic [15:0] DLY_MARK  = 16'hFFFF,
  parameter int unsigned DLY_UNIT  = 25000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        CLK_i,
  input  logic        rst,
  input  logic        start_i,
  output logic [9:0]  lut_index_o,
  input  logic [23:0] lut_data_i,
  input  logic [9:0]  lut_size_i,
  output logic        i2c_req_o,
  input  logic        i2c_ready_i,
  output logic [7:0]  i2c_dev_addr_o,
  output logic [15:0] i2c_reg_addr_o,
  output logic [7:0]  i2c_wdata_o,
  input  logic        i2c_done_i,
  input  logic        i2c_nack_i,
  output logic        busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o,
  output logic [9:0]  err_index_o
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PWR   = 4'd1;
  localparam logic [3:0] S_FETCH = 4'd2;
  localparam logic [3:0] S_ISSUE = 4'd3;
  localparam logic [3:0] S_WAIT  = 4'd4;
  localparam logic [3:0] S_DELAY = 4'd5;
  localparam logic [3:0] S_GAP   = 4'd6;
  localparam logic [3:0] S_NEXT  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_ERR   = 4'd9;

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  // Wait counters count down to zero, so load one less than the length.
  localparam logic [23:0] PWR_LD =
    (PWR_DLY > 0) ? 24'(PWR_DLY - 1) : 24'd0;
  localparam logic [23:0] GAP_LD =
    (GAP_CYC > 0) ? 24'(GAP_CYC - 1) : 24'd0;
  localparam logic [23:0] UNIT_W = 24'(DLY_UNIT);

  logic [3:0]    state;
  logic [23:0]   cnt;
  logic [9:0]    idx;
  logic [9:0]    idx_nx;
  logic [RW-1:0] retry;
  logic          pend;
  logic          boot;
  logic [23:0]   dly_ld;

  assign idx_nx = idx + 10'd1;
  assign dly_ld = {16'd0, lut_data_i[7:0]} * UNIT_W - 24'd1;

  assign lut_index_o    = idx;
  assign i2c_dev_addr_o = DEV_ADDR;
  assign i2c_req_o      = (state == S_ISSUE);
  assign busy_o = !(state == S_IDLE || state == S_DONE ||
                    state == S_ERR);

  always_ff @(posedge CLK_i) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= 24'd0;
      idx            <= 10'd0;
      retry          <= '0;
      pend           <= 1'b0;
      boot           <= 1'b1;
      i2c_reg_addr_o <= 16'd0;
      i2c_wdata_o    <= 8'd0;
      cfg_done_o     <= 1'b0;
      cfg_err_o      <= 1'b0;
      err_index_o    <= 10'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (boot || start_i) begin
            boot        <= 1'b0;
            cfg_done_o  <= 1'b0;
            cfg_err_o   <= 1'b0;
            err_index_o <= 10'd0;
            idx         <= 10'd0;
            retry       <= '0;
            pend        <= 1'b0;
            cnt         <= PWR_LD;
            state       <= S_PWR;
          end
        end
        S_PWR: begin
          if (cnt != 24'd0) begin
            cnt <= cnt - 24'd1;
          end else if (lut_size_i == 10'd0) begin
            cfg_done_o <= 1'b1;
            state      <= S_DONE;
          end else begin
            idx   <= 10'd0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (lut_data_i[23:8] == DLY_MARK) begin
            if (lut_data_i[7:0] == 8'd0) begin
              state <= S_NEXT;
            end else begin
              cnt   <= dly_ld;
              state <= S_DELAY;
            end
          end else begin
            i2c_reg_addr_o <= lut_data_i[23:8];
            i2c_wdata_o    <= lut_data_i[7:0];
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i2c_ready_i) state <= S_WAIT;
        end
        S_WAIT: begin
          if (i2c_done_i) begin
            cnt <= GAP_LD;
            if (!i2c_nack_i) begin
              retry <= '0;
              pend  <= 1'b0;
              state <= S_GAP;
            end else if (retry < RMAX) begin
              retry <= retry + 1'b1;
              pend  <= 1'b1;
              state <= S_GAP;
            end else begin
              cfg_err_o   <= 1'b1;
              err_index_o <= idx;
              state       <= S_ERR;
            end
          end
        end
        S_DELAY: begin
          if (cnt != 24'd0) cnt <= cnt - 24'd1;
          else              state <= S_NEXT;
        end
        S_GAP: begin
          if (cnt != 24'd0) cnt <= cnt - 24'd1;
          else              state <= pend ? S_ISSUE : S_NEXT;
        end
        S_NEXT: begin
          idx <= idx_nx;
          if (idx_nx == lut_size_i) begin
            cfg_done_o <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Bench for ov5640_cfg_sequencer: behavioural I2C master, LUT array and a
// table-level model of which writes must appear, in which order.
module tb_ov5640_cfg_sequencer;

  localparam int PWR  = 8;
  localparam int GAP  = 2;
  localparam int UNIT = 4;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [9:0]  lut_index;
  logic [23:0] lut_data;
  logic [9:0]  lut_size;
  logic        req, ready, done_p, nack;
  logic [7:0]  dev_addr;
  logic [15:0] reg_addr;
  logic [7:0]  wdata;
  logic        busy, cfg_done, cfg_err;
  logic [9:0]  err_index;

  ov5640_cfg_sequencer #(
    .DEV_ADDR(8'h78), .PWR_DLY(PWR), .GAP_CYC(GAP),
    .DLY_MARK(16'hFFFF), .DLY_UNIT(UNIT), .MAX_RETRY(MAXR)
  ) dut (
    .CLK_i(clk), .rst(rst), .start_i(start),
    .lut_index_o(lut_index), .lut_data_i(lut_data),
    .lut_size_i(lut_size), .i2c_req_o(req), .i2c_ready_i(ready),
    .i2c_dev_addr_o(dev_addr), .i2c_reg_addr_o(reg_addr),
    .i2c_wdata_o(wdata), .i2c_done_i(done_p), .i2c_nack_i(nack),
    .busy_o(busy), .cfg_done_o(cfg_done), .cfg_err_o(cfg_err),
    .err_index_o(err_index)
  );

  logic [23:0] lut [1024];
  int          nack_plan [1024];
  int          seen [1024];
  assign lut_data = lut[lut_index];

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  int          dcnt = 0;
  bit          pend_nack = 0;
  int          done_dly = 5;
  bit          rand_ready = 0;
  int          stall_left = 0, stall_seen = 0, stall_bad = 0;
  logic [15:0] st_addr;
  logic [7:0]  st_data;
  bit          stray = 0;
  logic [23:0] acc_q [$];
  int          acc_t [$];
  logic [23:0] exp_q [$];
  bit          e_err;
  int          e_idx;
  int          t_rel;

  // Master model: acts on the falling edge, DUT samples on the rising edge.
  always @(negedge clk) begin
    done_p = 1'b0;
    nack   = 1'b0;
    if (rst) begin
      dcnt  = 0;
      ready = 1'b0;
    end else begin
      if (stray) begin
        done_p = 1'b1;
        nack   = 1'($urandom_range(0, 1));
        stray  = 0;
      end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          done_p = 1'b1;
          nack   = pend_nack;
        end
      end
      if (req) begin
        if (stall_left > 0) begin
          if (stall_seen == 0) begin
            st_addr = reg_addr;
            st_data = wdata;
          end else if (reg_addr !== st_addr || wdata !== st_data) begin
            stall_bad++;
          end
          stall_seen++;
          stall_left--;
          ready = 1'b0;
        end else begin
          ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (ready) begin
          acc_q.push_back({reg_addr, wdata});
          acc_t.push_back(cyc);
          seen[lut_index]++;
          pend_nack = (seen[lut_index] <= nack_plan[lut_index]);
          dcnt = done_dly;
        end
      end else begin
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    acc_t.delete();
    foreach (seen[i]) seen[i] = 0;
    stall_seen = 0;
    stall_bad  = 0;
  endtask

  task automatic go_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_logs();
    rst   = 1'b0;
    t_rel = cyc;
  endtask

  task automatic go_start();
    @(negedge clk);
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_rel = cyc;
  endtask

  task automatic wait_end(input string tag, input int bound,
                          output int n);
    logic pb;
    pb = 1'b0;
    n  = 0;
    forever begin
      @(negedge clk);
      n++;
      if (cfg_done || cfg_err) break;
      pb = busy;
      if (n >= bound) break;
    end
    chk({tag, " finished"}, 32'(cfg_done || cfg_err), 1);
    chk({tag, " busy falls with status"}, {30'd0, pb, busy}, 2);
  endtask

  // Expected write stream, derived from the table and the NACK plan.
  task automatic model(input int size);
    exp_q.delete();
    e_err = 0;
    e_idx = 0;
    for (int i = 0; i < size; i++) begin
      if (lut[i][23:8] == 16'hFFFF) continue;
      for (int k = 0; k <= nack_plan[i] && k <= MAXR; k++)
        exp_q.push_back(lut[i]);
      if (nack_plan[i] > MAXR) begin
        e_err = 1;
        e_idx = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag);
    int mism;
    mism = 0;
    chk({tag, " accepts"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
      if (acc_q[i] !== exp_q[i]) mism++;
    chk({tag, " addr/data order"}, mism, 0);
    chk({tag, " done"}, 32'(cfg_done), 32'(!e_err));
    chk({tag, " err"}, 32'(cfg_err), 32'(e_err));
    chk({tag, " err_index"}, err_index, e_err ? e_idx : 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  initial begin
    int n, k, sz, r;
    rst = 1'b1;
    start = 1'b0;
    lut_size = 10'd3;
    foreach (lut[i]) begin
      lut[i] = 24'd0;
      nack_plan[i] = 0;
      seen[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst dev_addr", dev_addr, 8'h78);
    chk("rst req", req, 0);
    chk("rst busy", busy, 0);
    chk("rst done", cfg_done, 0);
    chk("rst err", cfg_err, 0);
    chk("rst index", lut_index, 0);
    chk("rst reg_addr", reg_addr, 0);
    chk("rst wdata", wdata, 0);
    chk("rst err_index", err_index, 0);

    lut[0] = 24'h300882;
    lut[1] = 24'h310311;
    lut[2] = 24'h430061;
    go_rst();
    wait_end("basic", 2000, n);
    model(3);
    check_result("basic");
    chk("power-up wait",
        32'(acc_t.size() > 0 && acc_t[0] - t_rel >= PWR), 1);

    lut[1] = 24'hFFFF05;
    go_rst();
    wait_end("delay", 2000, n);
    model(3);
    check_result("delay");
    chk("delay gap",
        32'(acc_t.size() >= 2 && acc_t[1] - acc_t[0] >= 5 * UNIT), 1);

    lut[1] = 24'h310311;
    nack_plan[2] = 2;
    go_rst();
    wait_end("nack2", 2000, n);
    model(3);
    check_result("nack2");

    nack_plan[2] = 99;
    go_rst();
    wait_end("nackerr", 2000, n);
    model(3);
    check_result("nackerr");
    nack_plan[2] = 0;
    go_start();
    chk("restart err cleared", cfg_err, 0);
    chk("restart busy", busy, 1);
    wait_end("restart", 2000, n);
    model(3);
    check_result("restart");

    stall_left = 10;
    go_rst();
    stall_left = 10;
    wait_end("stall", 2000, n);
    model(3);
    check_result("stall");
    chk("stall cycles", stall_seen, 10);
    chk("stall stable", stall_bad, 0);

    lut_size = 10'd0;
    go_rst();
    wait_end("size0", 200, n);
    model(0);
    check_result("size0");
    chk("size0 timing", 32'(n >= PWR && n <= PWR + 3), 1);

    lut_size = 10'd3;
    done_dly = 8;
    go_rst();
    k = 0;
    while (acc_q.size() < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("mid reset reached", 32'(acc_q.size() >= 2), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset req", req, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset status", {cfg_done, cfg_err, err_index}, 0);
    chk("mid reset index", lut_index, 0);
    clear_logs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    stray = 1;
    wait_end("replay", 2000, n);
    model(3);
    check_result("replay");

    rand_ready = 1;
    for (int it = 0; it < 8; it++) begin
      sz = $urandom_range(1, 12);
      lut_size = 10'(sz);
      done_dly = $urandom_range(1, 6);
      for (int i = 0; i < sz; i++) begin
        r = $urandom_range(0, 5);
        if (r == 0)
          lut[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
        else
          lut[i] = {16'($urandom_range(0, 16'hFFFE)),
                    8'($urandom_range(0, 255))};
        r = $urandom_range(0, 9);
        nack_plan[i] = (r < 6) ? 0 : r - 5;
      end
      if (it % 2 == 0) go_start();
      else             go_rst();
      wait_end("random", 5000, n);
      model(sz);
      check_result("random");
    end

    rand_ready = 0;
    done_dly = 1;
    lut_size = 10'd1023;
    for (int i = 0; i < 1023; i++) begin
      lut[i] = {16'($urandom_range(0, 16'hFFFE)),
                8'($urandom_range(0, 255))};
      nack_plan[i] = 0;
    end
    go_rst();
    wait_end("full", 20000, n);
    model(1023);
    check_result("full");
    chk("full final index", lut_index, 10'd1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ov5640_cfg_sequencer.md
Name: ov5640_cfg_sequencer

Overview:
- Sequences OV5640 register configuration over SCCB after power-up.
- Walks the config LUT one entry at a time: presents an index, reads back `{reg_addr[15:0], value[7:0]}`, and issues one write per entry to a byte-level I2C master through a req/ready/done handshake.
- Supports in-table delay entries, per-entry NACK retry, restart on request, and done/error status for the capture path.
- Sits between the LUT ROM and the I2C master; replaces free-running index stepping.

Parameters:
- DEV_ADDR, 8'h78, SCCB write device address driven on i2c_dev_addr_o.
- PWR_DLY, 20'hFFFF0, cycles to wait after reset/start before the first entry.
- GAP_CYC, 16, idle cycles between consecutive transactions.
- DLY_MARK, 16'hFFFF, reg_addr value that marks a delay entry (no I2C write).
- DLY_UNIT, 25000, cycles per delay-entry unit (1 ms at 25 MHz).
- MAX_RETRY, 3, re-issues of a NACKed entry before error.

Ports:
- CLK_i  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  pulse: (re)start configuration; honoured only in IDLE/DONE/ERROR
- lut_index_o  out  10  LUT entry index
- lut_data_i  in  24  `{reg_addr[15:0], value[7:0]}`, combinational from lut_index_o
- lut_size_i  in  10  number of LUT entries
- i2c_req_o  out  1  transaction request
- i2c_ready_i  in  1  master can accept; accept = req & ready in the same cycle
- i2c_dev_addr_o  out  8  device address (DEV_ADDR)
- i2c_reg_addr_o  out  16  register address
- i2c_wdata_o  out  8  write data
- i2c_done_i  in  1  one-cycle pulse: transaction finished
- i2c_nack_i  in  1  valid with i2c_done_i; 1 = NACK
- busy_o  out  1  sequencer active
- cfg_done_o  out  1  all entries written (level)
- cfg_err_o  out  1  aborted after retries (level)
- err_index_o  out  10  index of the failing entry

Behaviour:
- Reset values: all outputs 0, except i2c_dev_addr_o = DEV_ADDR.
- After rst deasserts, the FSM enters PWR_WAIT automatically; no start_i is needed after reset.
- States and transitions:
  - IDLE: no activity.
  - PWR_WAIT: count PWR_DLY cycles. Then go to DONE if lut_size_i == 0, else to FETCH with index 0.
  - FETCH: 1 cycle; lut_data_i is registered at the end of it. If reg_addr == DLY_MARK go to DELAY, else load i2c_reg_addr_o/i2c_wdata_o and go to ISSUE.
  - ISSUE: i2c_req_o = 1, held with stable address/data until i2c_ready_i. On the accept cycle, req drops the next cycle and the FSM goes to WAIT_DONE.
  - WAIT_DONE: wait for i2c_done_i.
    - nack = 0: clear the retry counter, go to GAP.
    - nack = 1 and retries < MAX_RETRY: increment retries, go to GAP, then re-ISSUE the same entry.
    - otherwise: go to ERROR.
  - DELAY: wait value × DLY_UNIT cycles; value 0 means 0 wait cycles. Then go to NEXT. Delay entries never NACK.
  - GAP: GAP_CYC idle cycles, then ISSUE (retry) or NEXT.
  - NEXT: increment the index. If index == lut_size_i go to DONE, else FETCH.
  - DONE: cfg_done_o = 1, busy_o = 0.
  - ERROR: cfg_err_o = 1, err_index_o = current index, busy_o = 0.
- busy_o = 1 in every state except IDLE, DONE and ERROR.
- start_i in IDLE/DONE/ERROR: clear done, err, index and retries, then go to PWR_WAIT. start_i is ignored while busy_o = 1.
- i2c_done_i outside WAIT_DONE is ignored.
- Counters are sized for their maxima; the delay counter is 24 bits or more.
- Index arithmetic is 10-bit and unsigned. lut_size_i = 1023 is legal; index never wraps.
- rst asserted mid-transaction:
  - next cycle all outputs return to reset values and i2c_req_o drops;
  - then PWR_WAIT restarts.
  - The I2C master is reset by the same rst.
- Minimum entry latency (ready = 1 immediately, done 1 cycle after accept): FETCH 1 + ISSUE 1 + WAIT_DONE ≥ 1 + GAP_CYC + NEXT 1.

Test Plan (PWR_DLY = 8, GAP_CYC = 2, DLY_UNIT = 4, MAX_RETRY = 3):
- 3-entry LUT {3008_82, 3103_11, 4300_61}, ready = 1, done 5 cycles after accept, no NACK → exactly 3 accepts carrying those address/data pairs in order; cfg_done_o rises; busy_o falls the same cycle.
- Entry 1 = FFFF_05 → no req for that entry; ≥ 20-cycle gap between the neighbouring accepts; done asserted.
- Entry 2 NACKs twice, then ACKs → 3 accepts of entry 2 with identical address/data; cfg_done_o = 1, cfg_err_o = 0.
- Entry 2 always NACKs → 4 accepts; cfg_err_o = 1, err_index_o = 2, cfg_done_o = 0. Then start_i → sequence restarts from index 0 with err cleared.
- ready held low 10 cycles → req stays high with stable address/data for those 10 cycles; accept is counted once. lut_size_i = 0 → done after PWR_DLY with no req.
- rst pulsed while in WAIT_DONE → next cycle req = 0 and status outputs = 0; a stray done pulse is ignored; sequence replays from index 0.
